multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Sequential multi-precision adder front end. Streams WORDS operand word pairs, least-significant word (LSW) first,
//  through one SIZE-bit fulladd. The carry is held in a register between words.
//  Sits directly upstream of fulladd: drives its a/b/cin and consumes its sum/carry.
//  Emits one registered sum word per accepted input, plus a final carry-out and a done pulse.
// PARAMETERS
//  SIZE   4  width of one operand/sum word (>=1)
//  WORDS  4  words per operation (>=2); total precision = SIZE*WORDS
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  start      in   1     begin operation; sampled only in IDLE
//  cin_init   in   1     carry into LSW, captured with start
//  in_valid   in   1     a_in/b_in hold a valid word pair
//  in_ready   out  1     block accepts a word pair this cycle
//  a_in       in   SIZE  operand A word
//  b_in       in   SIZE  operand B word
//  out_valid  out  1     sum_out/out_last valid
//  out_ready  in   1     downstream accepts sum_out
//  sum_out    out  SIZE  registered sum word
//  out_last   out  1     sum_out is the most-significant word (MSW)
//  cout       out  1     final carry; valid while done=1
//  done       out  1     one-cycle pulse: operation complete
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; carry_q, cnt, sum_out, out_valid, out_last, cout, done all 0; in_ready=0.
//  FSM states: IDLE, RUN, DRAIN.
//  IDLE: in_ready=0. start=1 -> carry_q<=cin_init, cnt<=0, go to RUN.
//  RUN:
//   - in_ready = !out_valid | out_ready.
//   - Accept = in_valid & in_ready.
//   - On accept: sum_out<=fulladd.sum(a_in, b_in, carry_q); carry_q<=fulladd.carry; out_valid<=1; out_last<=(cnt==WORDS-1); cnt<=cnt+1.
//   - On accepting word WORDS-1 -> DRAIN.
//  DRAIN: in_ready=0. When out_valid & out_ready (MSW taken) -> cout<=carry_q, done<=1 for one cycle, go to IDLE.
//  Output register: out_valid clears on out_ready unless a new word is accepted the same cycle.
//   - Accept and drain in the same cycle is allowed: full throughput of 1 word/cycle.
//  Latency: accept -> out_valid 1 cycle. sum_out and out_last hold stable while out_valid & !out_ready.
//  Counter: $clog2(WORDS) bits; no wrap inside an operation (reset to 0 on start).
//  Carry is chained only through carry_q, never combinationally across words.
//  start while busy: ignored. in_valid in IDLE/DRAIN: not accepted, no effect.
//  cout holds its value until the next start, which clears it to 0.
//  rst mid-operation: abort immediately to reset values; partial results are discarded.
// STRUCTURE
//  Shared package: FSM state encoding constants (IDLE/RUN/DRAIN); counter width function.
//  One sub-module: fulladd #(.SIZE(SIZE)), instantiated once.
//   - Combinational inputs: a_in, b_in, carry_q. Its sum/carry are registered here.
// TESTING (SIZE=4, WORDS=2 unless stated)
//  Case 1: cin_init=0; pairs (F,1),(0,0); out_ready=1
//   -> sums 0 then 1, out_last on 2nd word, cout=0, done pulse.
//  Case 2: cin_init=1; pairs (F,F),(F,F)
//   -> sums F, F; cout=1.
//  Case 3: backpressure: out_ready=0 for 3 cycles after 1st sum
//   -> sum_out held stable, in_ready=0, no word lost.
//  Case 4: WORDS=4; in_valid & out_ready held high every cycle
//   -> 4 sums on 4 consecutive cycles; results match a 16-bit reference add.
//  Case 5: rst asserted after 1st accepted word
//   -> next cycle: IDLE, out_valid=0, done=0; a new start then runs a correct operation.
//  Case 6: start pulsed during RUN, and in_valid held high in IDLE
//   -> both ignored; word count and result unchanged.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-precision adder.
//  - state_t   : FSM state encoding (IDLE / RUN / DRAIN)
//  - cnt_width : width of the word counter for a given word count
package multiword_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter width: $clog2(words), never less than one bit.
  function automatic int cnt_width(input int words);
    if (words > 2) begin
      return $clog2(words);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Bus bundle for multiword_add_seq.
//  Control : start, cin_init (in) / cout, done, busy (out)
//  Input   : in_valid, a_in, b_in (in) / in_ready (out)
//  Output  : sum_out, out_last, out_valid (out) / out_ready (in)
// modport slave  : the adder block
// modport master : the environment driving it
interface multiword_add_seq_if #(
  parameter int SIZE = 4
);
  logic            start;
  logic            cin_init;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a_in;
  logic [SIZE-1:0] b_in;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] sum_out;
  logic            out_last;
  logic            cout;
  logic            done;
  logic            busy;

  modport slave (
    input  start, cin_init, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum_out, out_last, cout, done, busy
  );

  modport master (
    output start, cin_init, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum_out, out_last, cout, done, busy
  );
endinterface

// File: rtl/multiword_add_seq_fulladd.sv
// fulladd: purely combinational SIZE-bit adder with carry in/out.
//  a, b  : operand words
//  cin   : carry in
//  sum   : SIZE-bit sum
//  carry : carry out of the MSB
module fulladd #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            carry
);

  // Extend by one bit so the carry falls out of the top of the sum.
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: streams WORDS operand word pairs (LSW first) through one
// fulladd, holding the carry in a register between words.
//  clk, rst : clock and synchronous active-high reset
//  bus      : slave side of multiword_add_seq_if (start/cin_init control,
//             valid/ready input stream, valid/ready sum stream, cout/done/busy)
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);

  localparam int CW = cnt_width(WORDS);

  state_t          state_r;
  state_t          state_nxt_s;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic [SIZE-1:0] sum_r;
  logic            out_valid_r;
  logic            out_last_r;
  logic            cout_r;
  logic            done_r;

  logic [SIZE-1:0] fa_sum_s;
  logic            fa_carry_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            last_word_s;
  logic            drain_take_s;

  // Carry enters only from carry_r, so words are never chained combinationally.
  fulladd #(.SIZE(SIZE)) u_fulladd (
    .a     (bus.a_in),
    .b     (bus.b_in),
    .cin   (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  assign in_ready_s   = (state_r == RUN) & (~out_valid_r | bus.out_ready);
  assign accept_s     = bus.in_valid & in_ready_s;
  assign last_word_s  = (cnt_r == CW'(WORDS - 1));
  assign drain_take_s = (state_r == DRAIN) & out_valid_r & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_word_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_take_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: carry chain, word counter, output register, cout/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      cout_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            carry_r <= bus.cin_init;
            cnt_r   <= '0;
            cout_r  <= 1'b0;
          end
        end
        RUN: begin
          if (accept_s) begin
            sum_r       <= fa_sum_s;
            carry_r     <= fa_carry_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_word_s;
            cnt_r       <= cnt_r + CW'(1);
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        DRAIN: begin
          // MSW leaves this cycle: publish the final carry.
          if (drain_take_s) begin
            out_valid_r <= 1'b0;
            cout_r      <= carry_r;
            done_r      <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum_out   = sum_r;
  assign bus.out_last  = out_last_r;
  assign bus.cout      = cout_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq.
// dut2: SIZE=4, WORDS=2 (cases 1,2,3,5,6); dut4: SIZE=4, WORDS=4 (case 4).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_multiword_add_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  multiword_add_seq_if #(.SIZE(4)) bus2 ();
  multiword_add_seq_if #(.SIZE(4)) bus4 ();

  multiword_add_seq #(.SIZE(4), .WORDS(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  multiword_add_seq #(.SIZE(4), .WORDS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full WORDS=2 operation on dut2 with out_ready held high.
  task automatic op2(input string tag, input logic cin,
                     input logic [3:0] a0, input logic [3:0] b0,
                     input logic [3:0] a1, input logic [3:0] b1,
                     input logic [3:0] s0, input logic [3:0] s1, input logic c);
    bus2.start    = 1'b1;
    bus2.cin_init = cin;
    step();
    bus2.start     = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.a_in      = a0;
    bus2.b_in      = b0;
    bus2.out_ready = 1'b1;
    #1;
    check({tag, ".rdy0"}, 32'(bus2.in_ready), 32'd1);
    step();
    check({tag, ".v0"}, 32'(bus2.out_valid), 32'd1);
    check({tag, ".s0"}, 32'(bus2.sum_out), 32'(s0));
    check({tag, ".l0"}, 32'(bus2.out_last), 32'd0);
    bus2.a_in = a1;
    bus2.b_in = b1;
    step();
    check({tag, ".s1"}, 32'(bus2.sum_out), 32'(s1));
    check({tag, ".l1"}, 32'(bus2.out_last), 32'd1);
    bus2.in_valid = 1'b0;
    #1;
    check({tag, ".rdy_drain"}, 32'(bus2.in_ready), 32'd0);
    step();
    check({tag, ".done"}, 32'(bus2.done), 32'd1);
    check({tag, ".cout"}, 32'(bus2.cout), 32'(c));
    check({tag, ".busy"}, 32'(bus2.busy), 32'd0);
    step();
    check({tag, ".done_pulse"}, 32'(bus2.done), 32'd0);
    check({tag, ".cout_hold"}, 32'(bus2.cout), 32'(c));
  endtask

  // WORDS=4 operation on dut4 against a 16-bit reference sum.
  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    bus4.start    = 1'b1;
    bus4.cin_init = cin;
    step();
    bus4.start     = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.a_in = a[i*4 +: 4];
      bus4.b_in = b[i*4 +: 4];
      #1;
      check({tag, ".rdy"}, 32'(bus4.in_ready), 32'd1);
      step();
      check({tag, ".v"}, 32'(bus4.out_valid), 32'd1);
      check({tag, ".s"}, 32'(bus4.sum_out), 32'(ref_sum[i*4 +: 4]));
      check({tag, ".l"}, 32'(bus4.out_last), (i == 3) ? 32'd1 : 32'd0);
    end
    bus4.in_valid = 1'b0;
    step();
    check({tag, ".done"}, 32'(bus4.done), 32'd1);
    check({tag, ".cout"}, 32'(bus4.cout), 32'(ref_sum[16]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus2.start = 1'b0; bus2.cin_init = 1'b0; bus2.in_valid = 1'b0;
    bus2.a_in = 4'h0;  bus2.b_in = 4'h0;     bus2.out_ready = 1'b0;
    bus4.start = 1'b0; bus4.cin_init = 1'b0; bus4.in_valid = 1'b0;
    bus4.a_in = 4'h0;  bus4.b_in = 4'h0;     bus4.out_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst.out_valid", 32'(bus2.out_valid), 32'd0);
    check("rst.done", 32'(bus2.done), 32'd0);
    check("rst.cout", 32'(bus2.cout), 32'd0);
    check("rst.sum", 32'(bus2.sum_out), 32'd0);
    check("rst.last", 32'(bus2.out_last), 32'd0);
    check("rst.busy", 32'(bus2.busy), 32'd0);
    check("rst.in_ready", 32'(bus2.in_ready), 32'd0);
    rst = 1'b0;
    step();

    // Case 1 and 2
    op2("c1", 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    op2("c2", 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);

    // Case 3: backpressure after first sum; 3+4=7, 5+6=B
    bus2.start = 1'b1; bus2.cin_init = 1'b0;
    step();
    check("c3.cout_cleared", 32'(bus2.cout), 32'd0);
    bus2.start = 1'b0; bus2.in_valid = 1'b1;
    bus2.a_in = 4'h3; bus2.b_in = 4'h4; bus2.out_ready = 1'b1;
    step();
    bus2.out_ready = 1'b0;
    bus2.a_in = 4'h5; bus2.b_in = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("c3.stall_rdy", 32'(bus2.in_ready), 32'd0);
      check("c3.stall_v", 32'(bus2.out_valid), 32'd1);
      check("c3.stall_s", 32'(bus2.sum_out), 32'h7);
      check("c3.stall_l", 32'(bus2.out_last), 32'd0);
      step();
    end
    bus2.out_ready = 1'b1;
    #1;
    check("c3.rdy_again", 32'(bus2.in_ready), 32'd1);
    step();
    check("c3.s1", 32'(bus2.sum_out), 32'hB);
    check("c3.l1", 32'(bus2.out_last), 32'd1);
    bus2.in_valid = 1'b0;
    step();
    check("c3.done", 32'(bus2.done), 32'd1);
    check("c3.cout", 32'(bus2.cout), 32'd0);
    step();

    // Case 4: WORDS=4, one word per cycle
    op4("c4a", 16'hF0F7, 16'h0F19, 1'b0);
    op4("c4b", 16'h1234, 16'h5678, 1'b1);

    // Case 5: reset after first accepted word, then a clean operation
    bus2.start = 1'b1; bus2.cin_init = 1'b1;
    step();
    bus2.start = 1'b0; bus2.in_valid = 1'b1;
    bus2.a_in = 4'hF; bus2.b_in = 4'h1; bus2.out_ready = 1'b0;
    step();
    check("c5.v_pre", 32'(bus2.out_valid), 32'd1);
    rst = 1'b1; bus2.in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("c5.busy", 32'(bus2.busy), 32'd0);
    check("c5.v", 32'(bus2.out_valid), 32'd0);
    check("c5.done", 32'(bus2.done), 32'd0);
    op2("c5r", 1'b0, 4'h8, 4'h8, 4'h1, 4'h2, 4'h0, 4'h4, 1'b0);

    // Case 6: in_valid in IDLE ignored; start during RUN ignored
    bus2.in_valid = 1'b1; bus2.a_in = 4'h7; bus2.b_in = 4'h7; bus2.out_ready = 1'b1;
    #1;
    check("c6.idle_rdy", 32'(bus2.in_ready), 32'd0);
    step();
    step();
    check("c6.idle_v", 32'(bus2.out_valid), 32'd0);
    check("c6.idle_busy", 32'(bus2.busy), 32'd0);
    bus2.in_valid = 1'b0;
    bus2.start = 1'b1; bus2.cin_init = 1'b0;
    step();
    bus2.start = 1'b1;
    bus2.in_valid = 1'b1; bus2.a_in = 4'h2; bus2.b_in = 4'h3;
    step();
    bus2.start = 1'b0;
    check("c6.s0", 32'(bus2.sum_out), 32'h5);
    check("c6.l0", 32'(bus2.out_last), 32'd0);
    bus2.a_in = 4'h4; bus2.b_in = 4'h4;
    step();
    check("c6.s1", 32'(bus2.sum_out), 32'h8);
    check("c6.l1", 32'(bus2.out_last), 32'd1);
    bus2.in_valid = 1'b0;
    step();
    check("c6.done", 32'(bus2.done), 32'd1);
    check("c6.cout", 32'(bus2.cout), 32'd0);
    check("c6.busy", 32'(bus2.busy), 32'd0);
    step();
    check("c6.v_end", 32'(bus2.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
